// File: rtl/audio_track_sequencer_if.sv
// Control and memory-strobe bundle between the audio track sequencer and its host.
// The master modport drives requests and configuration; the slave modport drives strobes and status.
interface audio_track_sequencer_if #(
    parameter int ADDR_W = 26,
    parameter int SEL_W  = 3
);
    logic              en;
    logic              start;
    logic              rec_mode;
    logic              stop;
    logic [SEL_W-1:0]  track_sel;
    logic [ADDR_W-1:0] max_mem_addr;
    logic              aud_rdy;
    logic              smp_req;
    logic              mem_busy;
    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic              read_en;
    logic              track_full;
    logic              play_done;
    logic              overrun;
    logic              sel_err;
    logic              busy;

    modport master (
        output en, start, rec_mode, stop, track_sel, max_mem_addr, aud_rdy, smp_req, mem_busy,
        input  address, write_en, read_en, track_full, play_done, overrun, sel_err, busy
    );

    modport slave (
        input  en, start, rec_mode, stop, track_sel, max_mem_addr, aud_rdy, smp_req, mem_busy,
        output address, write_en, read_en, track_full, play_done, overrun, sel_err, busy
    );
endinterface

// File: rtl/audio_track_sequencer.sv
// Multi-track record/playback address sequencer with a per-track recorded-length table.
// Define LOOP_PLAYBACK_EN to make playback of a non-empty track wrap to its base instead of ending.
//
// state    | meaning
// IDLE     | waiting for start
// REC      | waiting for a sample to write
// REC_GAP  | write strobe cycle; pointer and length table advance
// PLAY     | waiting for a playback request, or at end of recorded data
// PLAY_GAP | read strobe cycle; pointer advances
module audio_track_sequencer #(
    parameter int                ADDR_W      = 26,
    parameter int                NUM_TRACKS  = 5,
    parameter int                SEL_W       = 3,
    parameter logic [ADDR_W-1:0] TRACK_DEPTH = 26'h333333
) (
    input  logic                   clk,
    input  logic                   rst,
    audio_track_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REC, REC_GAP, PLAY, PLAY_GAP} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0]  trk_q, trk_d;
    logic              pend_q, pend_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              sel_err_q, sel_err_d;
    logic [ADDR_W-1:0] rec_end_q [NUM_TRACKS];
    logic [ADDR_W-1:0] rec_end_d [NUM_TRACKS];

    logic [ADDR_W-1:0] cur_base, cur_limit, cur_end, sel_base;
    logic [SEL_W-1:0]  sel_idx;
    logic              sel_ok, req_in, at_end, accept, done, wrap, latch;

    function automatic logic [ADDR_W-1:0] base_of(input logic [SEL_W-1:0] idx);
        return {{(ADDR_W-SEL_W){1'b0}}, idx} * TRACK_DEPTH;
    endfunction

    assign sel_idx   = bus.track_sel - SEL_W'(1);
    assign sel_base  = base_of(sel_idx);
    assign sel_ok    = (bus.track_sel != '0) && (bus.track_sel <= SEL_W'(NUM_TRACKS));
    assign cur_base  = base_of(trk_q);
    assign cur_limit = (trk_q == SEL_W'(NUM_TRACKS - 1)) ? bus.max_mem_addr
                                                         : cur_base + TRACK_DEPTH - ONE;

    always_comb begin
        cur_end = '0;
        for (int i = 0; i < NUM_TRACKS; i++)
            if (SEL_W'(i) == trk_q) cur_end = rec_end_q[i];
    end

    assign req_in = bus.en & (((state_q == REC) || (state_q == REC_GAP)) ? bus.aud_rdy :
                              ((state_q == PLAY) || (state_q == PLAY_GAP)) ? bus.smp_req : 1'b0);
    assign at_end = (ptr_q == cur_end);
    assign accept = bus.en & ~bus.stop & (req_in | pend_q) & ~bus.mem_busy &
                    ((state_q == REC) | ((state_q == PLAY) & ~at_end));
    assign done   = bus.en & ~bus.stop & (state_q == PLAY) & at_end;

`ifdef LOOP_PLAYBACK_EN
    assign wrap = done & (cur_end != cur_base);
`else
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            trk_q     <= '0;
            pend_q    <= 1'b0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            sel_err_q <= 1'b0;
            for (int i = 0; i < NUM_TRACKS; i++) rec_end_q[i] <= base_of(SEL_W'(i));
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            trk_q     <= trk_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sel_err_q <= sel_err_d;
            rec_end_q <= rec_end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            unique case (state_q)
                IDLE:     if (bus.start && sel_ok) state_d = bus.rec_mode ? REC : PLAY;
                REC:      if (bus.stop) state_d = IDLE;
                          else if (accept) state_d = REC_GAP;
                REC_GAP:  state_d = (bus.stop || ptr_q == cur_limit) ? IDLE : REC;
                PLAY:     if (bus.stop) state_d = IDLE;
                          else if (done) state_d = wrap ? PLAY : IDLE;
                          else if (accept) state_d = PLAY_GAP;
                PLAY_GAP: state_d = bus.stop ? IDLE : PLAY;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        trk_d     = trk_q;
        pend_d    = pend_q;
        full_d    = full_q;
        ovr_d     = ovr_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        sel_err_d = 1'b0;
        rec_end_d = rec_end_q;
        latch     = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    if (sel_ok) begin
                        trk_d  = sel_idx;
                        ptr_d  = sel_base;
                        full_d = 1'b0;
                        ovr_d  = 1'b0;
                        pend_d = 1'b0;
                        // A new recording discards whatever the track held before.
                        if (bus.rec_mode)
                            for (int i = 0; i < NUM_TRACKS; i++)
                                if (SEL_W'(i) == sel_idx) rec_end_d[i] = sel_base;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                REC: begin
                    if (bus.stop) pend_d = 1'b0;
                    else if (accept) begin
                        wr_d   = 1'b1;
                        pend_d = pend_q & req_in;
                    end else latch = 1'b1;
                end
                REC_GAP: begin
                    ptr_d = ptr_q + ONE;
                    for (int i = 0; i < NUM_TRACKS; i++)
                        if (SEL_W'(i) == trk_q) rec_end_d[i] = ptr_q + ONE;
                    if (ptr_q == cur_limit) full_d = 1'b1;
                    if (bus.stop || ptr_q == cur_limit) pend_d = 1'b0;
                    else latch = 1'b1;
                end
                PLAY: begin
                    if (bus.stop) pend_d = 1'b0;
                    else if (done) begin
                        if (wrap) begin
                            ptr_d = cur_base;
                            latch = 1'b1;
                        end else pend_d = 1'b0;
                    end else if (accept) begin
                        rd_d   = 1'b1;
                        pend_d = pend_q & req_in;
                    end else latch = 1'b1;
                end
                PLAY_GAP: begin
                    ptr_d = ptr_q + ONE;
                    if (bus.stop) pend_d = 1'b0;
                    else latch = 1'b1;
                end
                default: pend_d = 1'b0;
            endcase
            if (latch && req_in) begin
                if (pend_q) ovr_d = 1'b1;
                else pend_d = 1'b1;
            end
        end
    end

    assign bus.address    = ptr_q;
    assign bus.write_en   = wr_q & bus.en;
    assign bus.read_en    = rd_q & bus.en;
    assign bus.track_full = full_q;
    assign bus.play_done  = done;
    assign bus.overrun    = ovr_q;
    assign bus.sel_err    = sel_err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_audio_track_sequencer.sv
// Scoreboard bench for audio_track_sequencer: 3 tracks of 4 words, last track ending at 13.
// Build with LOOP_PLAYBACK_EN defined to exercise wrap-around playback instead of end-of-data stop.
module tb_audio_track_sequencer;
    localparam int ADDR_W = 26;
    localparam int SEL_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_track_sequencer_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

    audio_track_sequencer #(
        .ADDR_W(ADDR_W), .NUM_TRACKS(3), .SEL_W(SEL_W), .TRACK_DEPTH(26'd4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {bit wr; int addr; int at;} exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int pd_cnt = 0;
    int pd_last = -1;
    int last_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_strobe(input bit wr, input int addr, input int at);
        exp_t e;
        e.wr = wr; e.addr = addr; e.at = at;
        sb.push_back(e);
    endtask

    // One-cycle request pulse; a serviceable request strobes on the next cycle.
    task automatic req(input bit rec, input int addr, input bit expect_it);
        if (rec) bus.aud_rdy = 1'b1; else bus.smp_req = 1'b1;
        last_req = cyc;
        if (expect_it) expect_strobe(rec, addr, cyc + 1);
        tick();
        bus.aud_rdy = 1'b0;
        bus.smp_req = 1'b0;
    endtask

    task automatic start_op(input bit rec, input int trk);
        bus.start     = 1'b1;
        bus.rec_mode  = rec;
        bus.track_sel = SEL_W'(trk);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pd0;
        int p;
        exp_t e;
        bus.en = 1'b1; bus.start = 1'b0; bus.rec_mode = 1'b0; bus.stop = 1'b0;
        bus.track_sel = '0; bus.max_mem_addr = 26'd13;
        bus.aud_rdy = 1'b0; bus.smp_req = 1'b0; bus.mem_busy = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (sb.size() > 0 && sb[0].at < cyc) begin
                    chk("missed_strobe", cyc, sb[0].at);
                    void'(sb.pop_front());
                end
                if (bus.write_en || bus.read_en) begin
                    if (sb.size() == 0) chk("spurious_strobe", {bus.write_en, bus.read_en}, 0);
                    else begin
                        e = sb.pop_front();
                        chk("strobe_kind", {bus.write_en, bus.read_en}, e.wr ? 2 : 1);
                        chk("strobe_addr", bus.address, e.addr);
                        chk("strobe_cycle", cyc, e.at);
                    end
                end
                if (bus.play_done) begin
                    pd_cnt++;
                    pd_last = cyc;
                end
            end
        join_none

        idle(3);
        chk("rst_flags", {bus.busy, bus.write_en, bus.read_en, bus.track_full,
                          bus.play_done, bus.overrun, bus.sel_err}, 0);
        chk("rst_addr", bus.address, 0);
        rst = 1'b0;
        tick();

        // record track 2 until its region is exhausted
        start_op(1, 2);
        chk("rec_busy", bus.busy, 1);
        for (int i = 0; i < 6; i++) begin
            req(1, 4 + i, i < 4);
            idle(2);
        end
        chk("t2_full", bus.track_full, 1);
        chk("t2_idle", bus.busy, 0);

        // last track ends at max_mem_addr
        start_op(1, 3);
        chk("t3_full_cleared", bus.track_full, 0);
        for (int i = 0; i < 7; i++) begin
            req(1, 8 + i, i < 6);
            idle(2);
        end
        chk("t3_full", bus.track_full, 1);
        chk("t3_idle", bus.busy, 0);

        // invalid selections
        start_op(1, 0);
        chk("sel0_err", bus.sel_err, 1);
        chk("sel0_busy", bus.busy, 0);
        tick();
        chk("sel0_pulse", bus.sel_err, 0);
        start_op(0, 4);
        chk("sel4_err", bus.sel_err, 1);
        chk("sel4_busy", bus.busy, 0);
        tick();
        chk("sel4_pulse", bus.sel_err, 0);

        // partial record of track 1, then stop
        start_op(1, 1);
        for (int i = 0; i < 3; i++) begin
            req(1, i, 1);
            idle(2);
        end
        pulse_stop();
        chk("stop_idle", bus.busy, 0);
        chk("stop_not_full", bus.track_full, 0);

`ifndef LOOP_PLAYBACK_EN
        pd0 = pd_cnt;
        start_op(0, 1);
        chk("play_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            req(0, i, 1);
            idle(3);
        end
        p = last_req;
        chk("pd_count", pd_cnt - pd0, 1);
        chk("pd_cycle", pd_last, p + 2);
        chk("play_idle", bus.busy, 0);
        req(0, 3, 0);
        idle(2);
`endif

        // back-pressure: one request held pending
        start_op(1, 1);
        bus.mem_busy = 1'b1;
        req(1, 0, 0);
        idle(4);
        bus.mem_busy = 1'b0;
        expect_strobe(1, 0, cyc + 1);
        idle(3);
        chk("bp_no_overrun", bus.overrun, 0);

        // two requests while busy: second is lost
        bus.mem_busy = 1'b1;
        req(1, 1, 0);
        idle(1);
        req(1, 1, 0);
        idle(1);
        bus.mem_busy = 1'b0;
        expect_strobe(1, 1, cyc + 1);
        idle(3);
        chk("bp_overrun", bus.overrun, 1);
        pulse_stop();
        chk("overrun_sticky", bus.overrun, 1);

        // reset in the middle of recording track 2
        start_op(1, 2);
        chk("start_clears_overrun", bus.overrun, 0);
        req(1, 4, 1);
        idle(2);
        req(1, 5, 1);
        idle(1);
        rst = 1'b1;
        tick();
        chk("midrst_flags", {bus.busy, bus.write_en, bus.read_en, bus.track_full,
                             bus.play_done, bus.overrun, bus.sel_err}, 0);
        chk("midrst_addr", bus.address, 0);
        rst = 1'b0;
        tick();
        pd0 = pd_cnt;
        start_op(0, 2);
        req(0, 4, 0);
        idle(2);
        chk("empty_pd_count", pd_cnt - pd0, 1);
        chk("empty_idle", bus.busy, 0);

`ifdef LOOP_PLAYBACK_EN
        start_op(1, 1);
        req(1, 0, 1);
        idle(2);
        req(1, 1, 1);
        idle(2);
        pulse_stop();
        pd0 = pd_cnt;
        start_op(0, 1);
        p = cyc;
        for (int j = 0; j < 3; j++) begin
            expect_strobe(0, 0, p + 1 + 5 * j);
            expect_strobe(0, 1, p + 3 + 5 * j);
        end
        bus.smp_req = 1'b1;
        idle(15);
        chk("loop_busy", bus.busy, 1);
        chk("loop_pd_count", pd_cnt - pd0, 3);
        bus.smp_req = 1'b0;
        pulse_stop();
        chk("loop_stop_idle", bus.busy, 0);
`endif

        idle(4);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
